// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: EX-to-EX/MEM memory access control. Runs one req/ack data-bus
// transaction per load/store, formats load data, stalls the pipeline and flags faults.
`default_nettype none

module mem_access_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              ex_load,
  input  logic              ex_store,
  input  logic [2:0]        ex_funct3,
  input  logic [ADDR_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_store_data,
  output logic              mem_stall,
  output logic [DATA_W-1:0] mem_data_to_gpr,
  output logic              mem_done,
  output logic              mem_misalign,
  output logic              mem_bus_err,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [3:0]        dbus_be,
  output logic [DATA_W-1:0] dbus_wdata,
  input  logic              dbus_ack,
  input  logic [DATA_W-1:0] dbus_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int          CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] gpr_q, gpr_d;
  logic              done_q, done_d;
  logic              mis_q, mis_d;
  logic              err_q, err_d;
  logic              ld_q, ld_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;

  logic              access;
  logic              is_byte, is_half;
  logic              misaligned;
  logic [3:0]        st_be;
  logic [DATA_W-1:0] st_wdata;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_fmt;

  assign access  = ex_valid & (ex_load | ex_store);
  // Size comes from funct3[1:0]; every encoding other than B/H behaves as a word.
  assign is_byte = (ex_funct3[1:0] == 2'b00);
  assign is_half = (ex_funct3[1:0] == 2'b01);

  always_comb begin
    misaligned = 1'b0;
    if (is_half) begin
      misaligned = ex_alu_out[0];
    end else if (!is_byte) begin
      misaligned = (ex_alu_out[1:0] != 2'b00);
    end
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = ex_store_data;
    if (is_byte) begin
      st_be    = 4'b0001 << ex_alu_out[1:0];
      st_wdata = {(DATA_W/8){ex_store_data[7:0]}};
    end else if (is_half) begin
      st_be    = ex_alu_out[1] ? 4'b1100 : 4'b0011;
      st_wdata = {(DATA_W/16){ex_store_data[15:0]}};
    end
  end

  always_comb begin
    case (off_q)
      2'd0:    ld_byte = dbus_rdata[7:0];
      2'd1:    ld_byte = dbus_rdata[15:8];
      2'd2:    ld_byte = dbus_rdata[23:16];
      default: ld_byte = dbus_rdata[31:24];
    endcase
    ld_half = off_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
  end

  always_comb begin
    ld_fmt = dbus_rdata;
    if (f3_q[1:0] == 2'b00) begin
      ld_fmt = f3_q[2] ? {{(DATA_W-8){1'b0}}, ld_byte}
                       : {{(DATA_W-8){ld_byte[7]}}, ld_byte};
    end else if (f3_q[1:0] == 2'b01) begin
      ld_fmt = f3_q[2] ? {{(DATA_W-16){1'b0}}, ld_half}
                       : {{(DATA_W-16){ld_half[15]}}, ld_half};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    gpr_d     = gpr_q;
    done_d    = 1'b0;
    mis_d     = 1'b0;
    err_d     = 1'b0;
    ld_d      = ld_q;
    f3_d      = f3_q;
    off_d     = off_q;
    mem_stall = 1'b0;

    case (state_q)
      S_IDLE: begin
        mem_stall = access;
        if (access) begin
          if (misaligned) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            mis_d   = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = '0;
            req_d   = 1'b1;
            // A load wins when both load and store are flagged.
            we_d    = ~ex_load;
            addr_d  = {ex_alu_out[ADDR_W-1:2], 2'b00};
            be_d    = ex_load ? 4'b1111 : st_be;
            wdata_d = ex_load ? '0 : st_wdata;
            ld_d    = ex_load;
            f3_d    = ex_funct3;
            off_d   = ex_alu_out[1:0];
          end
        end
      end

      S_WAIT: begin
        mem_stall = 1'b1;
        if (dbus_ack) begin
          req_d   = 1'b0;
          state_d = S_DONE;
          done_d  = 1'b1;
          if (ld_q) begin
            gpr_d = ld_fmt;
          end
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          gpr_d   = '0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      gpr_q   <= '0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      ld_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      gpr_q   <= gpr_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      ld_q    <= ld_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
    end
  end

  assign mem_data_to_gpr = gpr_q;
  assign mem_done        = done_q;
  assign mem_misalign    = mis_q;
  assign mem_bus_err     = err_q;
  assign dbus_req        = req_q;
  assign dbus_we         = we_q;
  assign dbus_addr       = addr_q;
  assign dbus_be         = be_q;
  assign dbus_wdata      = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: table-driven load/store vectors with a scoreboard queue,
// plus hand-written reset, idle and non-memory sequences.
`default_nettype none

module tb_mem_access_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_load, ex_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu_out, ex_store_data;
  logic        mem_stall;
  logic [31:0] mem_data_to_gpr;
  logic        mem_done, mem_misalign, mem_bus_err;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .ex_funct3(ex_funct3), .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data),
    .mem_stall(mem_stall), .mem_data_to_gpr(mem_data_to_gpr),
    .mem_done(mem_done), .mem_misalign(mem_misalign), .mem_bus_err(mem_bus_err),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          ack_at;   // WAIT cycle that sees ack (1-based); 0 = never
    logic        mis;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        hold;     // expect mem_data_to_gpr unchanged
    logic [31:0] data;
    logic        err;
  } vec_t;

  typedef struct {
    logic        mis;
    logic        err;
    logic [31:0] data;
    int          waits;
  } exp_t;

  vec_t        vecs[14];
  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] gpr_model = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    exp_t e, got;
    int   waits;
    bit   seen_done;
    e.mis   = v.mis;
    e.err   = v.err;
    e.data  = v.hold ? gpr_model : v.data;
    e.waits = v.mis ? 0 : ((v.ack_at == 0) ? TIMEOUT : v.ack_at);

    @(negedge clk);
    chk($sformatf("v%0d done_clear", idx), {31'b0, mem_done}, 32'd0);
    ex_valid = 1'b1; ex_load = v.ld; ex_store = v.st; ex_funct3 = v.f3;
    ex_alu_out = v.addr; ex_store_data = v.sd;
    sb.push_back(e);
    #1;
    chk($sformatf("v%0d stall_idle", idx), {31'b0, mem_stall}, 32'd1);

    waits = 0;
    seen_done = 1'b0;
    for (int c = 0; c < TIMEOUT + 4 && !seen_done; c++) begin
      @(negedge clk);
      if (mem_done) begin
        seen_done = 1'b1;
        ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; dbus_ack = 1'b0;
        got = sb.pop_front();
        chk($sformatf("v%0d misalign", idx), {31'b0, mem_misalign}, {31'b0, got.mis});
        chk($sformatf("v%0d bus_err", idx), {31'b0, mem_bus_err}, {31'b0, got.err});
        chk($sformatf("v%0d gpr", idx), mem_data_to_gpr, got.data);
        chk($sformatf("v%0d waits", idx), waits, got.waits);
        chk($sformatf("v%0d stall_done", idx), {31'b0, mem_stall}, 32'd0);
        chk($sformatf("v%0d req_done", idx), {31'b0, dbus_req}, 32'd0);
        gpr_model = got.data;
      end else begin
        waits++;
        chk($sformatf("v%0d req", idx), {31'b0, dbus_req}, 32'd1);
        chk($sformatf("v%0d stall_wait", idx), {31'b0, mem_stall}, 32'd1);
        chk($sformatf("v%0d addr", idx), dbus_addr, {v.addr[31:2], 2'b00});
        chk($sformatf("v%0d we", idx), {31'b0, dbus_we}, {31'b0, v.we});
        chk($sformatf("v%0d be", idx), {28'b0, dbus_be}, {28'b0, v.be});
        if (v.we) chk($sformatf("v%0d wdata", idx), dbus_wdata, v.wdata);
        if (waits == v.ack_at) begin
          dbus_ack = 1'b1; dbus_rdata = v.rdata;
        end else begin
          dbus_ack = 1'b0; dbus_rdata = 32'h5A5A_5A5A;
        end
      end
    end
    if (!seen_done) begin
      chk($sformatf("v%0d done_timeout", idx), 32'd0, 32'd1);
      ex_valid = 1'b0; dbus_ack = 1'b0;
    end
  endtask

  initial begin
    //           ld    st    f3      addr          sd            rdata        ack mis  we    be       wdata         hold  data          err
    vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_0000, 1,  1'b0, 1'b0, 4'b1111, 32'h0,        1'b0, 32'hFFFF_FF80, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0,        3,  1'b0, 1'b1, 4'b1100, 32'hABCD_ABCD, 1'b1, 32'h0,        1'b0};
    vecs[2]  = '{1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0,        32'h0,         0,  1'b1, 1'b0, 4'b0000, 32'h0,        1'b1, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h0000_3002, 32'h0,        32'h8001_0000, 1,  1'b0, 1'b0, 4'b1111, 32'h0,        1'b0, 32'h0000_8001, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0,        32'h0,         0,  1'b0, 1'b0, 4'b1111, 32'h0,        1'b0, 32'h0,        1'b1};
    vecs[5]  = '{1'b1, 1'b0, 3'b010, 32'h0000_4004, 32'h0,        32'hDEAD_BEEF, 16, 1'b0, 1'b0, 4'b1111, 32'h0,        1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h0000_5001, 32'h0000_00A5, 32'h0,        2,  1'b0, 1'b1, 4'b0010, 32'hA5A5_A5A5, 1'b1, 32'h0,        1'b0};
    vecs[7]  = '{1'b1, 1'b0, 3'b001, 32'h0000_6000, 32'h0,        32'h1234_F00D, 1,  1'b0, 1'b0, 4'b1111, 32'h0,        1'b0, 32'hFFFF_F00D, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 3'b100, 32'h0000_6002, 32'h0,        32'h11AB_2233, 1,  1'b0, 1'b0, 4'b1111, 32'h0,        1'b0, 32'h0000_00AB, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 3'b010, 32'h0000_7000, 32'hCAFE_F00D, 32'h0,        1,  1'b0, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b1, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 1'b1, 3'b001, 32'h0000_7001, 32'h1111_2222, 32'h0,        0,  1'b1, 1'b0, 4'b0000, 32'h0,        1'b1, 32'h0,        1'b0};
    vecs[11] = '{1'b1, 1'b1, 3'b010, 32'h0000_8000, 32'h9999_9999, 32'h0102_0304, 1,  1'b0, 1'b0, 4'b1111, 32'h0,        1'b0, 32'h0102_0304, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 3'b011, 32'h0000_9002, 32'h0,        32'h0,         0,  1'b1, 1'b0, 4'b0000, 32'h0,        1'b1, 32'h0,        1'b0};
    vecs[13] = '{1'b1, 1'b0, 3'b000, 32'h0000_A000, 32'h0,        32'h0000_007F, 1,  1'b0, 1'b0, 4'b1111, 32'h0,        1'b0, 32'h0000_007F, 1'b0};

    reset = 1'b0;
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = 3'b000;
    ex_alu_out = 32'h0; ex_store_data = 32'h0;
    dbus_ack = 1'b0; dbus_rdata = 32'h0;

    #3;
    chk("rst stall", {31'b0, mem_stall}, 32'd0);
    chk("rst gpr", mem_data_to_gpr, 32'd0);
    chk("rst done/mis/err", {29'b0, mem_done, mem_misalign, mem_bus_err}, 32'd0);
    chk("rst req/we", {30'b0, dbus_req, dbus_we}, 32'd0);
    chk("rst addr", dbus_addr, 32'd0);
    chk("rst be", {28'b0, dbus_be}, 32'd0);
    chk("rst wdata", dbus_wdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run(vecs[i], i);
    end

    // Non-memory instruction plus a stray ack in IDLE: nothing may happen.
    @(negedge clk);
    ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b0;
    dbus_ack = 1'b1; dbus_rdata = 32'h7777_7777;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("nonmem stall", {31'b0, mem_stall}, 32'd0);
      chk("nonmem req", {31'b0, dbus_req}, 32'd0);
      chk("nonmem done", {31'b0, mem_done}, 32'd0);
      chk("nonmem gpr", mem_data_to_gpr, gpr_model);
    end
    ex_valid = 1'b0; dbus_ack = 1'b0;

    // Reset asserted in the middle of WAIT.
    @(negedge clk);
    ex_valid = 1'b1; ex_load = 1'b1; ex_funct3 = 3'b010; ex_alu_out = 32'h0000_B000;
    @(negedge clk);
    chk("rstwait req_before", {31'b0, dbus_req}, 32'd1);
    ex_valid = 1'b0; ex_load = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rstwait req", {31'b0, dbus_req}, 32'd0);
    chk("rstwait stall", {31'b0, mem_stall}, 32'd0);
    chk("rstwait addr", dbus_addr, 32'd0);
    chk("rstwait be", {28'b0, dbus_be}, 32'd0);
    chk("rstwait gpr", mem_data_to_gpr, 32'd0);
    chk("rstwait flags", {29'b0, mem_done, mem_misalign, mem_bus_err}, 32'd0);
    gpr_model = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst stall", {31'b0, mem_stall}, 32'd0);
      chk("post_rst req", {31'b0, dbus_req}, 32'd0);
      chk("post_rst done", {31'b0, mem_done}, 32'd0);
    end

    // A fresh access after the aborted one must run normally.
    run(vecs[13], 99);
    chk("scoreboard empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
